// File: rtl/shift_unit_scheduler.sv
// shift_unit_scheduler
//   Shared iterative shift/rotate engine serving two requesters through a
//   round-robin arbiter. Each accepted request is shifted by up to STEP bit
//   positions per cycle until its amount is used up; the result is then held
//   on a valid/ready port until the consumer takes it.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds valid and payload stable
// until that edge; ready may depend combinationally on valid.
//
// Ports
//   clk          clock, rising-edge
//   rst          synchronous reset, active low
//   req0Valid    requester 0 request present
//   req0Ready    requester 0 request accepted this cycle
//   req0Data     requester 0 operand
//   req0Mode     requester 0 mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   req0Amount   requester 0 shift amount (0..31)
//   req1*        same as requester 0, for requester 1
//   resValid     result available
//   resReady     consumer accepts result
//   resData      shifted / rotated value
//   resCarry     last bit shifted out (0 for amount 0)
//   resId        requester owning the result
//   busy         engine is in SHIFT or DONE
//   dbg_state    current FSM state (0 IDLE, 1 SHIFT, 2 DONE)

module shift_unit_scheduler #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0Valid,
    output logic        req0Ready,
    input  logic [31:0] req0Data,
    input  logic [1:0]  req0Mode,
    input  logic [4:0]  req0Amount,
    input  logic        req1Valid,
    output logic        req1Ready,
    input  logic [31:0] req1Data,
    input  logic [1:0]  req1Mode,
    input  logic [4:0]  req1Amount,
    output logic        resValid,
    input  logic        resReady,
    output logic [31:0] resData,
    output logic        resCarry,
    output logic        resId,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    localparam logic [4:0] STEP_K = 5'(STEP);

    state_t      state_q;
    state_t      state_d;
    logic        ptr_q;
    logic [31:0] cur_q;
    logic [1:0]  mode_q;
    logic [4:0]  rem_q;
    logic        carry_q;
    logic        id_q;

    // ---------------------------------------------------------------
    // Arbitration: a lone valid wins, otherwise the pointer decides.
    // ---------------------------------------------------------------
    logic        gnt;
    logic        in_idle;
    logic        accept;
    logic [31:0] sel_data;
    logic [1:0]  sel_mode;
    logic [4:0]  sel_amount;

    always_comb begin
        gnt = ptr_q;
        if (req0Valid && !req1Valid) begin
            gnt = 1'b0;
        end else if (req1Valid && !req0Valid) begin
            gnt = 1'b1;
        end
    end

    // Readys are suppressed while reset is held so nothing can be taken
    // on the reset edge.
    assign in_idle    = (state_q == IDLE) && rst;
    assign req0Ready  = in_idle && req0Valid && !gnt;
    assign req1Ready  = in_idle && req1Valid && gnt;
    assign accept     = req0Ready || req1Ready;
    assign sel_data   = gnt ? req1Data   : req0Data;
    assign sel_mode   = gnt ? req1Mode   : req0Mode;
    assign sel_amount = gnt ? req1Amount : req0Amount;

    // ---------------------------------------------------------------
    // One shift step of k = min(rem, STEP) positions.
    // The left/right shifts run on 33-bit vectors so the bit that falls
    // off the end lands in the extra position and becomes the carry.
    // ---------------------------------------------------------------
    logic [4:0]         step_k;
    logic [4:0]         rem_next;
    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_w;
    logic [31:0]        ror_v;
    logic [31:0]        step_data;
    logic               step_carry;

    assign step_k   = (rem_q > STEP_K) ? STEP_K : rem_q;
    assign rem_next = rem_q - step_k;

    always_comb begin
        lsl_w      = {1'b0, cur_q} << step_k;
        lsr_w      = {cur_q, 1'b0} >> step_k;
        asr_w      = $signed({cur_q, 1'b0}) >>> step_k;
        ror_v      = (cur_q >> step_k) | (cur_q << (6'd32 - {1'b0, step_k}));
        step_data  = ror_v;
        step_carry = lsr_w[0];
        case (mode_q)
            MODE_LSL: begin
                step_data  = lsl_w[31:0];
                step_carry = lsl_w[32];
            end
            MODE_LSR: begin
                step_data  = lsr_w[32:1];
                step_carry = lsr_w[0];
            end
            MODE_ASR: begin
                step_data  = asr_w[32:1];
                step_carry = asr_w[0];
            end
            default: begin
                // ROR: last bit rotated out is cur[k-1], same as LSR.
                step_data  = ror_v;
                step_carry = lsr_w[0];
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (sel_amount != 5'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (rem_next == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cur_q   <= 32'd0;
            mode_q  <= 2'b00;
            rem_q   <= 5'd0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cur_q   <= sel_data;
                mode_q  <= sel_mode;
                rem_q   <= sel_amount;
                carry_q <= 1'b0;
                id_q    <= gnt;
            end
            if (state_q == SHIFT) begin
                cur_q   <= step_data;
                carry_q <= step_carry;
                rem_q   <= rem_next;
            end
            // Hand priority to the other requester once a result drains.
            if ((state_q == DONE) && resReady) begin
                ptr_q <= ~id_q;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs: result registers are only written on accept/SHIFT, so they
    // stay frozen for the whole DONE stall.
    // ---------------------------------------------------------------
    assign resValid  = (state_q == DONE);
    assign resData   = cur_q;
    assign resCarry  = carry_q;
    assign resId     = id_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_unit_scheduler.sv
module tb_shift_unit_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0Valid, req0Ready;
  logic [31:0] req0Data;
  logic [1:0]  req0Mode;
  logic [4:0]  req0Amount;
  logic        req1Valid, req1Ready;
  logic [31:0] req1Data;
  logic [1:0]  req1Mode;
  logic [4:0]  req1Amount;
  logic        resValid, resReady;
  logic [31:0] resData;
  logic        resCarry, resId, busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  shift_unit_scheduler #(.STEP(8)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Data(req0Data),
    .req0Mode(req0Mode), .req0Amount(req0Amount),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Data(req1Data),
    .req1Mode(req1Mode), .req1Amount(req1Amount),
    .resValid(resValid), .resReady(resReady), .resData(resData),
    .resCarry(resCarry), .resId(resId), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input logic [31:0] d, input logic [1:0] m, input logic [4:0] a);
    if (id) begin
      req1Valid = 1'b1; req1Data = d; req1Mode = m; req1Amount = a;
    end else begin
      req0Valid = 1'b1; req0Data = d; req0Mode = m; req0Amount = a;
    end
  endtask

  // One full operation from a single requester, resReady held high.
  // exp_cyc is the result cycle index relative to the accept edge T
  // (amount 0 -> 1, amount a -> 1 + ceil(a/8)).
  task automatic run_op(input bit id, input logic [31:0] d, input logic [1:0] m, input logic [4:0] a,
                        input logic [31:0] exp_data, input logic exp_carry, input int exp_cyc, input string nm);
    int t;
    int edges;
    logic rdy;
    drive_req(id, d, m, a);
    #1;
    t = 0;
    rdy = id ? req1Ready : req0Ready;
    while (!rdy && t < 20) begin
      step_cycle();
      t++;
      rdy = id ? req1Ready : req0Ready;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready=%b required 1 within 20 cycles", nm, rdy);
      req0Valid = 1'b0; req1Valid = 1'b0;
      return;
    end
    step_cycle();  // accept edge
    req0Valid = 1'b0; req1Valid = 1'b0;
    edges = 0;
    while (resValid !== 1'b1 && edges < 40) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_in_shift: got %b required 1", nm, busy);
      end
      step_cycle();
      edges++;
    end
    checks++;
    if (edges + 1 != exp_cyc) begin
      errors++;
      $display("FAIL %s latency: result at T+%0d required T+%0d", nm, edges + 1, exp_cyc);
    end
    checks++;
    if (resData !== exp_data) begin
      errors++;
      $display("FAIL %s data: got %h required %h", nm, resData, exp_data);
    end
    checks++;
    if (resCarry !== exp_carry) begin
      errors++;
      $display("FAIL %s carry: got %b required %b", nm, resCarry, exp_carry);
    end
    checks++;
    if (resId !== id) begin
      errors++;
      $display("FAIL %s id: got %b required %b", nm, resId, id);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b required 1", nm, busy);
    end
    step_cycle();  // handshake edge
    checks++;
    if (resValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: resValid=%b busy=%b required 0 0", nm, resValid, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    req0Valid = 1'b1; req1Valid = 1'b1;
    step_cycle();
    step_cycle();
    checks++;
    if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b required 00", req0Ready, req1Ready);
    end
    checks++;
    if (resValid !== 1'b0 || resData !== 32'd0 || resCarry !== 1'b0 || resId !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h carry=%b id=%b busy=%b required all 0",
               resValid, resData, resCarry, resId, busy);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    rst = 1'b1;
    step_cycle();
  endtask

  task automatic test_shift_modes();
    run_op(1'b0, 32'h0000_0001, 2'b00, 5'd31, 32'h8000_0000, 1'b0, 5, "lsl_1_31");
    run_op(1'b0, 32'h8000_0000, 2'b10, 5'd4,  32'hF800_0000, 1'b0, 2, "asr_4");
    run_op(1'b0, 32'h8000_0000, 2'b01, 5'd4,  32'h0800_0000, 1'b0, 2, "lsr_4");
    run_op(1'b0, 32'h0000_00FF, 2'b11, 5'd8,  32'hFF00_0000, 1'b1, 2, "ror_8");
    run_op(1'b0, 32'h0000_0001, 2'b11, 5'd1,  32'h8000_0000, 1'b1, 2, "ror_1");
    run_op(1'b1, 32'h1234_5678, 2'b01, 5'd0,  32'h1234_5678, 1'b0, 1, "lsr_0_req1");
    run_op(1'b1, 32'h8000_0000, 2'b10, 5'd31, 32'hFFFF_FFFF, 1'b0, 5, "asr_31_neg");
    run_op(1'b0, 32'h8000_0001, 2'b00, 5'd1,  32'h0000_0002, 1'b1, 2, "lsl_1_carry");
    run_op(1'b1, 32'hFFFF_FFFF, 2'b00, 5'd12, 32'hFFFF_F000, 1'b1, 3, "lsl_12_split");
    run_op(1'b0, 32'hF000_0000, 2'b01, 5'd17, 32'h0000_7800, 1'b0, 4, "lsr_17");
    run_op(1'b1, 32'h1234_5678, 2'b11, 5'd16, 32'h5678_1234, 1'b0, 3, "ror_16");
    run_op(1'b0, 32'h0000_0001, 2'b11, 5'd0,  32'h0000_0001, 1'b0, 1, "ror_0_no_rrx");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    logic        exp_carry;
    bit          exp_id;
    int          t;
    // fresh reset so the pointer starts at 0
    rst = 1'b0;
    step_cycle();
    rst = 1'b1;
    resReady = 1'b0;
    drive_req(1'b0, 32'h0000_000F, 2'b00, 5'd4);
    drive_req(1'b1, 32'h0000_00FF, 2'b11, 5'd8);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id    = (i % 2) == 1;
      exp_data  = exp_id ? 32'hFF00_0000 : 32'h0000_00F0;
      exp_carry = exp_id;
      t = 0;
      while (!(req0Ready || req1Ready) && t < 20) begin
        step_cycle();
        t++;
      end
      checks++;
      if (req0Ready !== !exp_id || req1Ready !== exp_id) begin
        errors++;
        $display("FAIL arb_grant[%0d]: ready0=%b ready1=%b required %b %b",
                 i, req0Ready, req1Ready, !exp_id, exp_id);
      end
      step_cycle();  // accept edge
      t = 0;
      while (resValid !== 1'b1 && t < 20) begin
        step_cycle();
        t++;
      end
      checks++;
      if (resValid !== 1'b1 || resId !== exp_id || resData !== exp_data || resCarry !== exp_carry) begin
        errors++;
        $display("FAIL arb_result[%0d]: valid=%b id=%b data=%h carry=%b required 1 %b %h %b",
                 i, resValid, resId, resData, resCarry, exp_id, exp_data, exp_carry);
      end
      if (i == 0) begin
        for (int s = 0; s < 3; s++) begin
          step_cycle();
          checks++;
          if (resValid !== 1'b1 || resData !== exp_data || resCarry !== exp_carry || resId !== exp_id
              || req0Ready !== 1'b0 || req1Ready !== 1'b0 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL stall[%0d]: valid=%b data=%h carry=%b id=%b rdy=%b%b state=%0d required 1 %h %b %b 00 2",
                     s, resValid, resData, resCarry, resId, req0Ready, req1Ready, dbg_state,
                     exp_data, exp_carry, exp_id);
          end
        end
      end
      resReady = 1'b1;
      step_cycle();  // handshake edge
      resReady = 1'b0;
      checks++;
      if (resValid !== 1'b0) begin
        errors++;
        $display("FAIL arb_release[%0d]: resValid=%b required 0", i, resValid);
      end
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    resReady = 1'b1;
    step_cycle();
  endtask

  task automatic test_reset_mid_shift();
    int t;
    // leave the pointer at 1 before the reset
    run_op(1'b0, 32'h8000_0000, 2'b10, 5'd4, 32'hF800_0000, 1'b0, 2, "pre_reset");
    drive_req(1'b0, 32'hFFFF_0000, 2'b01, 5'd20);
    #1;
    t = 0;
    while (req0Ready !== 1'b1 && t < 20) begin
      step_cycle();
      t++;
    end
    step_cycle();  // accept edge
    req0Valid = 1'b0;
    step_cycle();
    checks++;
    if (dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL mid_shift_state: got %0d required 1", dbg_state);
    end
    rst = 1'b0;
    step_cycle();
    checks++;
    if (resValid !== 1'b0 || resData !== 32'd0 || resCarry !== 1'b0 || resId !== 1'b0
        || busy !== 1'b0 || req0Ready !== 1'b0 || req1Ready !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b data=%h carry=%b id=%b busy=%b rdy=%b%b state=%0d required all 0",
               resValid, resData, resCarry, resId, busy, req0Ready, req1Ready, dbg_state);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      checks++;
      if (resValid !== 1'b0) begin
        errors++;
        $display("FAIL discarded[%0d]: resValid=%b required 0", i, resValid);
      end
    end
    // both valid: pointer must be back at 0
    drive_req(1'b0, 32'h8000_0000, 2'b01, 5'd4);
    drive_req(1'b1, 32'h0000_0001, 2'b11, 5'd1);
    #1;
    checks++;
    if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      errors++;
      $display("FAIL ptr_after_reset: ready0=%b ready1=%b required 1 0", req0Ready, req1Ready);
    end
    step_cycle();  // accept requester 0
    req0Valid = 1'b0;
    t = 0;
    while (resValid !== 1'b1 && t < 20) begin
      step_cycle();
      t++;
    end
    checks++;
    if (resValid !== 1'b1 || resData !== 32'h0800_0000 || resCarry !== 1'b0 || resId !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: valid=%b data=%h carry=%b id=%b required 1 08000000 0 0",
               resValid, resData, resCarry, resId);
    end
    step_cycle();  // handshake; requester 1 still waiting
    t = 0;
    while (req1Ready !== 1'b1 && t < 20) begin
      step_cycle();
      t++;
    end
    step_cycle();  // accept requester 1
    req1Valid = 1'b0;
    t = 0;
    while (resValid !== 1'b1 && t < 20) begin
      step_cycle();
      t++;
    end
    checks++;
    if (resValid !== 1'b1 || resData !== 32'h8000_0000 || resCarry !== 1'b1 || resId !== 1'b1) begin
      errors++;
      $display("FAIL waiting_req1: valid=%b data=%h carry=%b id=%b required 1 80000000 1 1",
               resValid, resData, resCarry, resId);
    end
    step_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    req0Valid = 1'b0; req0Data = '0; req0Mode = '0; req0Amount = '0;
    req1Valid = 1'b0; req1Data = '0; req1Mode = '0; req1Amount = '0;
    resReady = 1'b1;
    #1;
    test_reset();
    test_shift_modes();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_unit_scheduler.md
# shift_unit_scheduler

Shared, multi-cycle shift/rotate engine with a two-requester round-robin arbiter. It serves the operand-2 path and the address/auxiliary path of the execute stage, so one iterative shifter replaces two full barrel shifters. Each request carries an operand, a mode (LSL/LSR/ASR/ROR) and a 5-bit amount. The block returns the shifted value plus the shifter carry-out through a valid/ready result port.

## Interface
Parameters:
- STEP, 8, maximum shift distance applied per SHIFT cycle; power of two, 1..16

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- req0Valid  input  1  requester 0 has a request
- req0Ready  output  1  requester 0 request accepted this cycle
- req0Data  input  32  requester 0 operand
- req0Mode  input  2  requester 0 mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR
- req0Amount  input  5  requester 0 shift amount
- req1Valid, req1Ready, req1Data, req1Mode, req1Amount  same as requester 0, for requester 1
- resValid  output  1  result available
- resReady  input  1  consumer accepts result
- resData  output  32  shifted/rotated value
- resCarry  output  1  last bit shifted out; 0 when amount is 0
- resId  output  1  requester that owns the result
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester named by the priority pointer `ptr` (reset 0).
  - reqNReady is high only in IDLE, for the granted requester, and only while its valid is high. It is combinational from the valids.
- Accept (valid && ready): capture data into `cur`, mode, amount into `rem`, id into resId; clear carry.
  - Next state is SHIFT if amount != 0, otherwise DONE.
- SHIFT, each cycle:
  - k = min(rem, STEP).
  - cur shifts by k per mode. LSL zero-fills. LSR zero-fills. ASR sign-fills from cur[31]. ROR rotates right.
  - carry = cur[32-k] for LSL, else cur[k-1] (uses pre-step cur).
  - rem -= k. When the updated rem is 0, go to DONE.
- Composition of steps equals a single shift by the full amount, carry included.
- DONE:
  - resValid=1; resData=cur; resCarry=carry.
  - All result outputs are held stable until resValid && resReady.
  - On handshake, go to IDLE and set ptr = ~resId (the other requester gets priority).
- Requesters hold valid and payload stable until ready. Payload changes while not accepted are ignored.
- Amount 0 with any mode is a pass-through: resData = operand, resCarry=0. ROR #0 is not RRX.
- Width rules: amounts range 0..31 only; no 32-bit shifts. ASR 31 of a negative value gives 0xFFFFFFFF.

## Timing
- Reset (rst low at a clk edge), effective the same edge:
  - State IDLE, ptr=0.
  - resValid=0, resData=0, resCarry=0, resId=0, busy=0.
  - req0Ready=req1Ready=0 while rst is low.
- Reset mid-SHIFT or mid-DONE discards the in-flight operation; no result is ever presented for it.
- Accept at edge T:
  - Amount 0: resValid high in cycle T+1.
  - Amount a>0: resValid high in cycle T+1+ceil(a/STEP). With STEP=8, a=31 gives T+5.
- Result handshake at edge H: IDLE in cycle H+1. The earliest next accept is at edge H+1, so there is one bubble per operation.
- Throughput, back-to-back amount-0 requests: one result every 2 cycles (accept, DONE+handshake).
- Simultaneous valids in IDLE: exactly one ready is asserted; the loser waits, its valid held.
- resReady low in DONE stalls indefinitely. No ready is asserted and no state changes.
- resReady high outside DONE has no effect.

## Test plan
- LSL 0x00000001 #31, STEP=8, resReady=1 -> resData 0x80000000, resCarry 0, resValid exactly 5 cycles after accept, busy high for those cycles.
- ASR 0x80000000 #4 -> resData 0xF8000000, carry 0, valid at T+2. Also LSR 0x80000000 #4 -> 0x08000000.
- ROR 0x000000FF #8 -> resData 0xFF000000, carry 1. ROR 0x00000001 #1 -> 0x80000000, carry 1.
- LSR 0x12345678 #0 from requester 1 -> resData 0x12345678, carry 0, resId 1, valid at T+1.
- Both requesters valid continuously after reset with distinct operands:
  - Accept order is 0,1,0,1 and resId alternates.
  - With resReady low for 3 cycles in DONE, result outputs stay stable and both readys stay 0.
- Assert rst low during SHIFT of a #20 request:
  - Next cycle all outputs are 0 and state is IDLE.
  - The following request completes with the correct value, ptr restarting at 0.
